// File: rtl/cordic_sincos_q16.sv
// Iterative rotation-mode CORDIC: first-quadrant Q16.16 degree angle in, Q16.16 sin/cos of the
// original (quadrant/sign-restored) angle out, one micro-rotation per clock.
module cordic_sincos_q16 #(
   parameter int ITER   = 16,
   parameter int X_INIT = 39797
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] theta_in,
   input  logic [1:0]  kuadran,
   input  logic        isNegative,
   output logic        in_ready,
   output logic        busy,
   output logic [31:0] sin_out,
   output logic [31:0] cos_out,
   output logic        out_valid
);

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_CORRECT} state_t;

   localparam logic signed [33:0] THETA_MAX = 34'sd5898240;
   localparam logic signed [33:0] UNIT      = 34'sd65536;

   state_t             state_q;
   logic signed [33:0] x_q, y_q, z_q;
   logic [4:0]         iter_q;
   logic               quad2_q, neg_q;
   logic [31:0]        sin_q, cos_q;
   logic               valid_q;

   logic signed [31:0] theta_s;
   logic signed [33:0] theta_clamp_d;
   logic signed [33:0] atan_d, x_rot_d, y_rot_d, z_rot_d;
   logic signed [31:0] s_sat_d, c_sat_d;

   // Only the Q1/Q2 distinction matters downstream; bit 1 carries no information here.
   logic unused_kuadran;
   assign unused_kuadran = kuadran[1];

   function automatic logic signed [33:0] atan_lut(input logic [4:0] i);
      case (i)
         5'd0:    atan_lut = 34'sd2949120;
         5'd1:    atan_lut = 34'sd1740967;
         5'd2:    atan_lut = 34'sd919879;
         5'd3:    atan_lut = 34'sd466945;
         5'd4:    atan_lut = 34'sd234379;
         5'd5:    atan_lut = 34'sd117304;
         5'd6:    atan_lut = 34'sd58666;
         5'd7:    atan_lut = 34'sd29335;
         5'd8:    atan_lut = 34'sd14668;
         5'd9:    atan_lut = 34'sd7334;
         5'd10:   atan_lut = 34'sd3667;
         5'd11:   atan_lut = 34'sd1833;
         5'd12:   atan_lut = 34'sd917;
         5'd13:   atan_lut = 34'sd458;
         5'd14:   atan_lut = 34'sd229;
         5'd15:   atan_lut = 34'sd115;
         default: atan_lut = 34'sd0;
      endcase
   endfunction

   function automatic logic signed [31:0] sat_unit(input logic signed [33:0] v);
      if (v > UNIT)
         sat_unit = 32'sd65536;
      else if (v < -UNIT)
         sat_unit = -32'sd65536;
      else
         sat_unit = v[31:0];
   endfunction

   always_comb begin
      theta_s       = theta_in;
      theta_clamp_d = {{2{theta_s[31]}}, theta_s};
      if (theta_s < 0)
         theta_clamp_d = '0;
      else if (theta_clamp_d > THETA_MAX)
         theta_clamp_d = THETA_MAX;

      atan_d = atan_lut(iter_q);
      // Rotate toward z = 0: positive residual angle means rotate counter-clockwise.
      if (z_q >= 0) begin
         x_rot_d = x_q - (y_q >>> iter_q);
         y_rot_d = y_q + (x_q >>> iter_q);
         z_rot_d = z_q - atan_d;
      end else begin
         x_rot_d = x_q + (y_q >>> iter_q);
         y_rot_d = y_q - (x_q >>> iter_q);
         z_rot_d = z_q + atan_d;
      end

      s_sat_d = sat_unit(y_q);
      c_sat_d = sat_unit(x_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         quad2_q <= 1'b0;
         neg_q   <= 1'b0;
         sin_q   <= '0;
         cos_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q     <= 34'(X_INIT);
                  y_q     <= '0;
                  z_q     <= theta_clamp_d;
                  iter_q  <= '0;
                  quad2_q <= kuadran[0];
                  neg_q   <= isNegative;
                  state_q <= S_ROTATE;
               end
            end
            S_ROTATE: begin
               x_q    <= x_rot_d;
               y_q    <= y_rot_d;
               z_q    <= z_rot_d;
               iter_q <= iter_q + 5'd1;
               if (iter_q == 5'(ITER - 1))
                  state_q <= S_CORRECT;
            end
            S_CORRECT: begin
               // Q2 mirror flips cosine only; a negative original angle flips sine only.
               cos_q   <= quad2_q ? -c_sat_d : c_sat_d;
               sin_q   <= neg_q ? -s_sat_d : s_sat_d;
               valid_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = ~in_ready;
   assign sin_out   = sin_q;
   assign cos_out   = cos_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_cordic_sincos_q16.sv
// Self-checking bench for cordic_sincos_q16: directed cases plus random angles compared against
// a floating-point sin/cos reference of the restored original angle.
module tb_cordic_sincos_q16;

   localparam int ITER = 16;
   localparam int LAT  = ITER + 1;
   localparam int TOL  = 8;
   localparam real PI  = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] theta_in = '0;
   logic [1:0]  kuadran = '0;
   logic        isNegative = 1'b0;
   logic        in_ready, busy, out_valid;
   logic [31:0] sin_out, cos_out;

   int n_checks = 0;
   int n_fail   = 0;

   cordic_sincos_q16 #(.ITER(ITER), .X_INIT(39797)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .theta_in   (theta_in),
      .kuadran    (kuadran),
      .isNegative (isNegative),
      .in_ready   (in_ready),
      .busy       (busy),
      .sin_out    (sin_out),
      .cos_out    (cos_out),
      .out_valid  (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
      longint diff;
      n_checks++;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint rnd(input real v);
      return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
   endfunction

   // Reference: clamp, restore the original angle from its quadrant/sign flags, take sin/cos.
   task automatic ref_model(input int theta, input logic [1:0] k, input logic neg,
                            output longint s, output longint c);
      int  th;
      real a;
      th = theta;
      if (th < 0) th = 0;
      if (th > 5898240) th = 5898240;
      a = real'(th) / 65536.0;
      if (k[0]) a = 180.0 - a;
      if (neg) a = -a;
      s = rnd(65536.0 * $sin(a * PI / 180.0));
      c = rnd(65536.0 * $cos(a * PI / 180.0));
   endtask

   task automatic drive(input int theta, input logic [1:0] k, input logic neg);
      in_valid   = 1'b1;
      theta_in   = theta;
      kuadran    = k;
      isNegative = neg;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic check_result(input string tag, input int theta, input logic [1:0] k, input logic neg);
      longint es, ec;
      ref_model(theta, k, neg, es, ec);
      check_val({tag, "_sin"}, longint'($signed(sin_out)), es, TOL);
      check_val({tag, "_cos"}, longint'($signed(cos_out)), ec, TOL);
      $display("%s theta=%0d k=%0d neg=%0d sin=%0d (ref %0d) cos=%0d (ref %0d)", tag, theta, k, neg,
               $signed(sin_out), es, $signed(cos_out), ec);
   endtask

   task automatic do_op(input string tag, input int theta, input logic [1:0] k, input logic neg);
      int lat;
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 40) begin
         step();
         cnt++;
      end
      check_val({tag, "_rdy"}, longint'(in_ready), 1, 0);
      drive(theta, k, neg);
      step();
      in_valid   = 1'b0;
      theta_in   = $urandom;
      kuadran    = 2'($urandom);
      isNegative = 1'($urandom);
      check_val({tag, "_busy"}, longint'(busy), 1, 0);
      wait_result(lat);
      check_val({tag, "_lat"}, longint'(lat), LAT, 0);
      check_val({tag, "_rdy_on_valid"}, longint'(in_ready), 1, 0);
      check_result(tag, theta, k, neg);
      step();
      check_val({tag, "_pulse"}, longint'(out_valid), 0, 0);
      check_result({tag, "_hold"}, theta, k, neg);
   endtask

   initial begin
      int lat, pulses;
      int theta_a, theta_b;

      repeat (3) step();
      rst = 1'b0;
      check_val("rst_sin", longint'(sin_out), 0, 0);
      check_val("rst_cos", longint'(cos_out), 0, 0);
      check_val("rst_valid", longint'(out_valid), 0, 0);
      check_val("rst_ready", longint'(in_ready), 1, 0);
      check_val("rst_busy", longint'(busy), 0, 0);

      do_op("t1_zero", 0, 2'b00, 1'b0);
      do_op("t2_30deg", 1966080, 2'b00, 1'b0);
      do_op("t3_m120", 3932160, 2'b01, 1'b1);
      do_op("t4_90", 5898240, 2'b00, 1'b0);
      do_op("t4_100clamp", 6553600, 2'b00, 1'b0);
      do_op("t4_negclamp", -65536, 2'b00, 1'b0);
      do_op("t4_q2_90", 5898240, 2'b11, 1'b1);

      // Mid-operation input is dropped; back-to-back accept on the out_valid cycle.
      theta_a = 2949120;
      theta_b = 1310720;
      drive(theta_a, 2'b00, 1'b1);
      step();
      in_valid = 1'b0;
      lat = 0;
      repeat (4) begin
         step();
         lat++;
      end
      drive(5000000, 2'b01, 1'b0);
      step();
      lat++;
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check_val("t5_lat_a", longint'(lat), LAT, 0);
      check_result("t5_a", theta_a, 2'b00, 1'b1);
      drive(theta_b, 2'b01, 1'b0);
      wait_result(lat);
      in_valid = 1'b0;
      check_val("t5_gap", longint'(lat), ITER + 2, 0);
      check_result("t5_b", theta_b, 2'b01, 1'b0);
      pulses = 0;
      repeat (30) begin
         step();
         if (out_valid) pulses++;
      end
      check_val("t5_no_extra", longint'(pulses), 0, 0);

      // Reset partway through the rotations aborts the operation.
      drive(4000000, 2'b00, 1'b0);
      step();
      in_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("t6_sin", longint'(sin_out), 0, 0);
      check_val("t6_cos", longint'(cos_out), 0, 0);
      check_val("t6_ready", longint'(in_ready), 1, 0);
      check_val("t6_busy", longint'(busy), 0, 0);
      check_val("t6_valid", longint'(out_valid), 0, 0);
      pulses = 0;
      repeat (30) begin
         step();
         if (out_valid) pulses++;
      end
      check_val("t6_no_valid", longint'(pulses), 0, 0);

      for (int i = 0; i < 24; i++) begin
         int th;
         th = int'($urandom_range(7208960, 0)) - 327680;
         do_op("rand", th, 2'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
